sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/sram_arb_rr.sv | 21 ++
 rtl/sram_arbiter.sv | 154 +++++++++++++++
 tb/tb_sram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared definitions for the two-port SRAM arbiter:
//     ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
//     port_t                  : requester index (PORT0 / PORT1)
//     rd_entry_t              : one read-tracking pipeline entry (valid + port)
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    typedef struct packed {
        logic  valid;
        port_t port;
    } rd_entry_t;

endpackage

// File: rtl/sram_arb_rr.sv
// sram_arb_rr
//   Two-way round-robin picker. A lone requester always wins; on a
//   conflict the port that was not granted last wins.
//   Ports:
//     req0, req1 : pending requests (already qualified by reset)
//     last       : port granted most recently
//     gnt0, gnt1 : one-hot (or zero) grant
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic  req0,
    input  logic  req1,
    input  port_t last,
    output logic  gnt0,
    output logic  gnt1
);

    assign gnt0 = req0 & (~req1 | (last == PORT1));
    assign gnt1 = req1 & (~req0 | (last == PORT0));

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Arbitrates two requesters onto a single-port SRAM macro, one access per
//   cycle, and returns read data to the issuing port with a latency of two.
//   Parameters: ADDR_W (word-address width), DATA_W (data width, multiple of 8)
//   Ports:
//     CLK, RST_N                         : clock, asynchronous active-low reset
//     Pn_REQ/WE/ADDR/WDATA/BE (n=0,1)    : request, held stable until Pn_GNT
//     Pn_GNT                             : access issued this cycle (combinational)
//     Pn_RVALID, Pn_RDATA                : one-cycle read completion, held data
//     SRAM_ADDR/DIN/BM/MEN/WEN/REN       : macro controls (active-high)
//     SRAM_DOUT                          : macro read data, valid the cycle after a read
//   Configuration macro:
//     SRAM_ARB_FIXED_PRIO_EN : port 0 wins every conflict, no round-robin state.
//                              Undefined (default): round-robin arbitration.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,

    input  logic                P0_REQ,
    input  logic                P0_WE,
    input  logic [ADDR_W-1:0]   P0_ADDR,
    input  logic [DATA_W-1:0]   P0_WDATA,
    input  logic [DATA_W/8-1:0] P0_BE,
    output logic                P0_GNT,
    output logic                P0_RVALID,
    output logic [DATA_W-1:0]   P0_RDATA,

    input  logic                P1_REQ,
    input  logic                P1_WE,
    input  logic [ADDR_W-1:0]   P1_ADDR,
    input  logic [DATA_W-1:0]   P1_WDATA,
    input  logic [DATA_W/8-1:0] P1_BE,
    output logic                P1_GNT,
    output logic                P1_RVALID,
    output logic [DATA_W-1:0]   P1_RDATA,

    output logic [ADDR_W-1:0]   SRAM_ADDR,
    output logic [DATA_W-1:0]   SRAM_DIN,
    output logic [DATA_W-1:0]   SRAM_BM,
    output logic                SRAM_MEN,
    output logic                SRAM_WEN,
    output logic                SRAM_REN,
    input  logic [DATA_W-1:0]   SRAM_DOUT
);

    localparam int unsigned BE_W = DATA_W / 8;

    // Requests are masked while reset is asserted so the macro stays idle
    // regardless of what the requesters drive.
    logic req0;
    logic req1;

    assign req0 = P0_REQ & RST_N;
    assign req1 = P1_REQ & RST_N;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign P0_GNT = req0;
    assign P1_GNT = req1 & ~req0;
`else
    port_t last;

    sram_arb_rr u_rr (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .gnt0 (P0_GNT),
        .gnt1 (P1_GNT)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last <= PORT1;
        end else if (P0_GNT) begin
            last <= PORT0;
        end else if (P1_GNT) begin
            last <= PORT1;
        end
    end
`endif

    // Macro drive: winner's fields in a grant cycle, all-zero otherwise.
    logic            sel_we;
    logic [BE_W-1:0] sel_be;

    always_comb begin
        sel_we    = 1'b0;
        sel_be    = '0;
        SRAM_MEN  = 1'b0;
        SRAM_WEN  = 1'b0;
        SRAM_REN  = 1'b0;
        SRAM_ADDR = '0;
        SRAM_DIN  = '0;
        SRAM_BM   = '0;
        if (P1_GNT) begin
            sel_we    = P1_WE;
            sel_be    = P1_BE;
            SRAM_ADDR = P1_ADDR;
            SRAM_DIN  = P1_WDATA;
        end else if (P0_GNT) begin
            sel_we    = P0_WE;
            sel_be    = P0_BE;
            SRAM_ADDR = P0_ADDR;
            SRAM_DIN  = P0_WDATA;
        end
        if (P0_GNT || P1_GNT) begin
            SRAM_MEN = 1'b1;
            SRAM_WEN = sel_we;
            SRAM_REN = ~sel_we;
            if (sel_we) begin
                for (int unsigned k = 0; k < BE_W; k++) begin
                    SRAM_BM[8*k +: 8] = {8{sel_be[k]}};
                end
            end
        end
    end

    // Read tracking: rd_s1 marks the cycle SRAM_DOUT is valid (capture),
    // rd_s2 marks the cycle the captured data is presented with RVALID.
    rd_entry_t rd_s1;
    rd_entry_t rd_s2;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_s1 <= '0;
            rd_s2 <= '0;
        end else begin
            rd_s1.valid <= SRAM_REN;
            rd_s1.port  <= P1_GNT ? PORT1 : PORT0;
            rd_s2       <= rd_s1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            P0_RDATA <= '0;
            P1_RDATA <= '0;
        end else if (rd_s1.valid) begin
            if (rd_s1.port == PORT1) begin
                P1_RDATA <= SRAM_DOUT;
            end else begin
                P0_RDATA <= SRAM_DOUT;
            end
        end
    end

    assign P0_RVALID = rd_s2.valid && (rd_s2.port == PORT0);
    assign P1_RVALID = rd_s2.valid && (rd_s2.port == PORT1);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Testbench for sram_arbiter with a behavioural SRAM macro attached.
//   A reference model (shadow memory, queue of pending read completions,
//   last-granted port) predicts every output each cycle.
module tb_sram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          P0_REQ, P0_WE, P1_REQ, P1_WE;
    logic [AW-1:0] P0_ADDR, P1_ADDR;
    logic [DW-1:0] P0_WDATA, P1_WDATA;
    logic [BW-1:0] P0_BE, P1_BE;
    logic          P0_GNT, P1_GNT, P0_RVALID, P1_RVALID;
    logic [DW-1:0] P0_RDATA, P1_RDATA;
    logic [AW-1:0] SRAM_ADDR;
    logic [DW-1:0] SRAM_DIN, SRAM_BM, SRAM_DOUT;
    logic          SRAM_MEN, SRAM_WEN, SRAM_REN;

    always #5 CLK = ~CLK;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_ADDR(P0_ADDR), .P0_WDATA(P0_WDATA), .P0_BE(P0_BE),
        .P0_GNT(P0_GNT), .P0_RVALID(P0_RVALID), .P0_RDATA(P0_RDATA),
        .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_ADDR(P1_ADDR), .P1_WDATA(P1_WDATA), .P1_BE(P1_BE),
        .P1_GNT(P1_GNT), .P1_RVALID(P1_RVALID), .P1_RDATA(P1_RDATA),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DIN(SRAM_DIN), .SRAM_BM(SRAM_BM),
        .SRAM_MEN(SRAM_MEN), .SRAM_WEN(SRAM_WEN), .SRAM_REN(SRAM_REN),
        .SRAM_DOUT(SRAM_DOUT)
    );

    // Behavioural SRAM macro: registered read, bit-masked write.
    logic [DW-1:0] sram_mem [1<<AW];

    always @(posedge CLK) begin
        if (SRAM_MEN && SRAM_REN) SRAM_DOUT <= sram_mem[SRAM_ADDR];
        if (SRAM_MEN && SRAM_WEN)
            sram_mem[SRAM_ADDR] = (sram_mem[SRAM_ADDR] & ~SRAM_BM) | (SRAM_DIN & SRAM_BM);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned   due;
        int            port;
        logic [DW-1:0] data;
    } pend_t;

    pend_t         pend[$];
    logic [DW-1:0] shadow [1<<AW];
    logic [DW-1:0] exp_rd [2];
    int            last_g;
    int            cur_win;
    int unsigned   cyc = 0;

    task automatic model_reset();
        last_g    = 1;
        pend.delete();
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // Called once per cycle, at the falling edge.
    task automatic check_cycle();
        int            win;
        logic          we, men;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, m;
        logic [BW-1:0] be;
        logic [1:0]    rv;
        win = -1;
        if (RST_N) begin
            if (P0_REQ && P1_REQ) win = FIXED ? 0 : 1 - last_g;
            else if (P0_REQ)      win = 0;
            else if (P1_REQ)      win = 1;
        end
        chk("gnt0", 64'(P0_GNT), 64'(win == 0));
        chk("gnt1", 64'(P1_GNT), 64'(win == 1));
        if (win == 1) begin we = P1_WE; a = P1_ADDR; wd = P1_WDATA; be = P1_BE; end
        else          begin we = P0_WE; a = P0_ADDR; wd = P0_WDATA; be = P0_BE; end
        for (int k = 0; k < BW; k++) m[8*k +: 8] = be[k] ? 8'hFF : 8'h00;
        men = (win >= 0);
        chk("sram_men",  64'(SRAM_MEN),  64'(men));
        chk("sram_wen",  64'(SRAM_WEN),  64'(men && we));
        chk("sram_ren",  64'(SRAM_REN),  64'(men && !we));
        chk("sram_addr", 64'(SRAM_ADDR), men ? 64'(a) : 64'd0);
        chk("sram_din",  64'(SRAM_DIN),  men ? 64'(wd) : 64'd0);
        chk("sram_bm",   64'(SRAM_BM),   (men && we) ? 64'(m) : 64'd0);
        rv = 2'b00;
        while (pend.size() > 0 && pend[0].due == cyc) begin
            exp_rd[pend[0].port] = pend[0].data;
            rv[pend[0].port]     = 1'b1;
            void'(pend.pop_front());
        end
        chk("rvalid0", 64'(P0_RVALID), 64'(rv[0]));
        chk("rvalid1", 64'(P1_RVALID), 64'(rv[1]));
        chk("rdata0",  64'(P0_RDATA),  64'(exp_rd[0]));
        chk("rdata1",  64'(P1_RDATA),  64'(exp_rd[1]));
        if (win >= 0) begin
            last_g = win;
            if (we) shadow[a] = (shadow[a] & ~m) | (wd & m);
            else    pend.push_back('{cyc + 2, win, shadow[a]});
        end
        cur_win = win;
        cyc++;
    endtask

    // ---------------- stimulus helpers ----------------
    typedef struct {
        logic          v;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
    } txn_t;

    function automatic txn_t t_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        t_wr = '{1'b1, 1'b1, a, d, be};
    endfunction

    function automatic txn_t t_rd(input logic [AW-1:0] a);
        t_rd = '{1'b1, 1'b0, a, '0, '0};
    endfunction

    function automatic txn_t t_idle();
        t_idle = '{1'b0, 1'b0, '0, '0, '0};
    endfunction

    function automatic txn_t t_rand();
        txn_t t;
        t.v  = ($urandom_range(0, 9) < 7);
        t.we = 1'($urandom_range(0, 1));
        t.a  = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
        t.d  = $urandom;
        t.be = 4'($urandom_range(0, 15));
        return t;
    endfunction

    task automatic drive(input txn_t t0, input txn_t t1);
        P0_REQ = t0.v; P0_WE = t0.we; P0_ADDR = t0.a; P0_WDATA = t0.d; P0_BE = t0.be;
        P1_REQ = t1.v; P1_WE = t1.we; P1_ADDR = t1.a; P1_WDATA = t1.d; P1_BE = t1.be;
    endtask

    typedef struct {
        txn_t          p0;
        txn_t          p1;
        logic          g0;
        logic          g1;
        logic          chk_rd;
        logic          v0;
        logic          v1;
        logic [DW-1:0] q0;
        logic [DW-1:0] q1;
    } vec_t;

    vec_t vecs[$];
    txn_t ag[2];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = $urandom;
            shadow[i]   = sram_mem[i];
        end
        model_reset();
        drive(t_rd(10'h001), t_rd(10'h002));

        // Reset with both ports requesting: macro must stay idle.
        #1 RST_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); check_cycle();
            @(posedge CLK); #1;
        end
        RST_N = 1'b1;
        drive(t_idle(), t_idle());

        // Directed table: {P0 txn, P1 txn, gnt0, gnt1, check-read?, rvalid0, rvalid1, rdata0, rdata1}
        vecs.push_back('{t_wr(10'h005, 32'hDEADBEEF, 4'hF), t_idle(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{t_rd(10'h005), t_idle(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{t_idle(), t_wr(10'h001, 32'h11, 4'hF), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{t_idle(), t_wr(10'h002, 32'h22, 4'hF), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{t_wr(10'h3FF, 32'hFFFFFFFF, 4'hF), t_idle(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{t_wr(10'h3FF, 32'h00000000, 4'h2), t_idle(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{t_rd(10'h3FF), t_idle(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{t_rd(10'h001), t_idle(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{t_idle(), t_rd(10'h002), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF00FF, 32'h0});
        vecs.push_back('{t_idle(), t_idle(), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11, 32'h0});
        vecs.push_back('{t_idle(), t_idle(), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11, 32'h22});
        vecs.push_back('{t_wr(10'h005, 32'h12345678, 4'h0), t_idle(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h11, 32'h22});
        vecs.push_back('{t_rd(10'h005), t_idle(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h11, 32'h22});
        vecs.push_back('{t_idle(), t_wr(10'h003, 32'h0, 4'hF), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11, 32'h22});
        vecs.push_back('{t_idle(), t_idle(), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h22});
        vecs.push_back('{t_rd(10'h001), t_rd(10'h002), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{t_rd(10'h001), t_rd(10'h002), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{t_rd(10'h001), t_rd(10'h002), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{t_rd(10'h001), t_rd(10'h002), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{t_idle(), t_idle(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{t_idle(), t_idle(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});

        @(posedge CLK); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            logic e0, e1;
            drive(vecs[i].p0, vecs[i].p1);
            e0 = vecs[i].g0;
            e1 = vecs[i].g1;
            if (FIXED && vecs[i].p0.v && vecs[i].p1.v) begin e0 = 1'b1; e1 = 1'b0; end
            @(negedge CLK);
            check_cycle();
            chk($sformatf("vec%0d_gnt0", i), 64'(P0_GNT), 64'(e0));
            chk($sformatf("vec%0d_gnt1", i), 64'(P1_GNT), 64'(e1));
            if (vecs[i].chk_rd) begin
                chk($sformatf("vec%0d_rvalid0", i), 64'(P0_RVALID), 64'(vecs[i].v0));
                chk($sformatf("vec%0d_rvalid1", i), 64'(P1_RVALID), 64'(vecs[i].v1));
                chk($sformatf("vec%0d_rdata0", i),  64'(P0_RDATA),  64'(vecs[i].q0));
                chk($sformatf("vec%0d_rdata1", i),  64'(P1_RDATA),  64'(vecs[i].q1));
            end
            @(posedge CLK); #1;
        end

        // Reset pulsed in the cycle after a read grant.
        drive(t_rd(10'h005), t_idle());
        @(negedge CLK); check_cycle();
        chk("rst_read_gnt", 64'(P0_GNT), 64'd1);
        @(posedge CLK); #1;
        drive(t_rd(10'h001), t_rd(10'h002));
        #2 RST_N = 1'b0;
        model_reset();
        #1;
        chk("rst_men_low",  64'(SRAM_MEN),  64'd0);
        chk("rst_rdata0",   64'(P0_RDATA),  64'd0);
        chk("rst_rvalid0",  64'(P0_RVALID), 64'd0);
        @(negedge CLK); check_cycle();
        @(posedge CLK); #1;
        @(negedge CLK); check_cycle();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK); check_cycle();
        chk("rst_conflict_p0", 64'(P0_GNT),   64'd1);
        chk("rst_conflict_p1", 64'(P1_GNT),   64'd0);
        chk("rst_rdata0_zero", 64'(P0_RDATA), 64'd0);
        @(posedge CLK); #1;
        drive(t_idle(), t_idle());
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); check_cycle();
            @(posedge CLK); #1;
        end

        // Randomized traffic; each requester holds its access until granted.
        ag[0] = t_rand();
        ag[1] = t_rand();
        for (int i = 0; i < 3000; i++) begin
            drive(ag[0], ag[1]);
            @(negedge CLK); check_cycle();
            @(posedge CLK); #1;
            for (int p = 0; p < 2; p++)
                if (!ag[p].v || cur_win == p) ag[p] = t_rand();
        end

        drive(t_idle(), t_idle());
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); check_cycle();
            @(posedge CLK); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
